pwm_spd_decode: RTL and testbench
=================================

PWM_SPD_DECODE -- requirements
Module: pwm_spd_decode

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- PERIOD, 2048, nominal PWM period in clk cycles (11-bit PWM).
- DEAD_MAX, 4, max consecutive cycles pwm_in == pwm_in_n tolerated.
- TIMEOUT, 4096, cycles without a rising edge before stall.
REQ-002 SHALL have ports, one per line: name direction width meaning:
- clk input 1 single system clock; all logic on rising edge.
- rst_n input 1 synchronous, active-low reset.
- pwm_in input 1 asynchronous PWM, high time = duty.
- pwm_in_n input 1 asynchronous complement of pwm_in.
- spd output signed 11 recovered speed = duty - 1024.
- spd_vld output 1 one-cycle strobe, spd updated.
- per_err output 1 one-cycle pulse, bad period length.
- pair_err output 1 one-cycle pulse, complement violation.
- stall output 1 level, no edges within TIMEOUT.

Function
REQ-003 SHALL pass pwm_in and pwm_in_n each through a 2-flop synchronizer before any use.
REQ-004 SHALL detect a rising edge as sync_now=1 and sync_prev=0 on synchronized pwm_in.
REQ-005 SHALL keep an FSM with states IDLE, MEASURE, STALL_LO, STALL_HI.
REQ-006 IDLE -> MEASURE on the first rising edge; no spd_vld from IDLE (partial period discarded).
REQ-007 In MEASURE, per_cnt (12 bit, saturating 4095) SHALL count cycles since last rising edge and hi_cnt (11 bit, saturating 2047) cycles with synchronized pwm_in high.
REQ-008 On a rising edge in MEASURE with per_cnt == PERIOD and no pair violation that period: spd <= hi_cnt - 1024 (11-bit two's complement, i.e. MSB inverted), spd_vld pulses.
REQ-009 On a rising edge in MEASURE with per_cnt != PERIOD: per_err pulses, spd holds, no spd_vld.
REQ-010 Every rising edge SHALL restart per_cnt = 1 and hi_cnt = 1 (edge cycle counts as high).
REQ-011 spd_vld/per_err SHALL assert exactly 3 clk edges after the clk edge that first samples raw pwm_in high.
REQ-012 If synchronized pwm_in == pwm_in_n for more than DEAD_MAX consecutive cycles: pair_err pulses once per violation run and current period is flagged (REQ-008 suppressed).
REQ-013 If per_cnt reaches TIMEOUT in IDLE or MEASURE: go STALL_LO if pwm_in low (spd <= -1024, spd_vld pulses once), else STALL_HI (spd holds, no spd_vld); stall = 1 in both.
REQ-014 STALL_x -> MEASURE on next rising edge; stall clears same cycle; that edge produces no spd_vld.
REQ-015 Rising edge and timeout in the same cycle: edge wins.

Reset
REQ-016 With rst_n = 0 at a clk edge: FSM = IDLE, counters, sync flops = 0, spd = 0, spd_vld = per_err = pair_err = stall = 0.
REQ-017 Reset mid-period SHALL discard the period in progress; measurement restarts per REQ-006.

Structure
REQ-018 PERIOD/TIMEOUT/DEAD_MAX defaults, the SPD_OFFSET constant (1024) and the FSM state enum SHALL live in the shared motor package.
REQ-019 The 2-flop synchronizer SHALL be a sub-module sync2, instantiated twice.

Verification
REQ-020 Duty 0x400, period 2048, complement exact -> from 2nd rising edge spd = 0, spd_vld every 2048 cycles, no errors.
REQ-021 Duty 0x600 then 0x100 -> spd = +512, then -768 on the first full period after change.
REQ-022 Duty 0 held 4096 cycles -> stall = 1, spd = -1024, single spd_vld; restore duty 0x400 -> stall clears at edge, next period spd = 0.
REQ-023 Period 2000 cycles, duty 1000 -> per_err per edge, no spd_vld, spd unchanged.
REQ-024 pwm_in_n = pwm_in for 10 cycles mid-period -> one pair_err, that period's spd_vld suppressed; 3-cycle overlap -> no error.
REQ-025 rst_n low 1 cycle mid-period -> all outputs 0 next cycle; first post-reset partial period produces no spd_vld.

Source files
------------

// File: rtl/pwm_spd_decode_pkg.sv
// Shared motor package: default timing parameters, speed offset and decoder FSM states.
package pwm_spd_decode_pkg;

    localparam int PERIOD_DEF   = 2048;
    localparam int DEAD_MAX_DEF = 4;
    localparam int TIMEOUT_DEF  = 4096;

    localparam logic [10:0] SPD_OFFSET = 11'd1024;
    localparam logic [10:0] SPD_MIN    = 11'd0 - SPD_OFFSET;

    typedef enum logic [1:0] {
        IDLE,
        MEASURE,
        STALL_LO,
        STALL_HI
    } state_e;

    // High-time count to signed speed; subtracting 1024 from 11 bits just flips the MSB.
    function automatic logic [10:0] hi_to_spd(input logic [10:0] hi);
        return hi - SPD_OFFSET;
    endfunction

endpackage

// File: rtl/pwm_spd_decode_sync2.sv
// Two-flop synchronizer for a single asynchronous input bit.
module sync2
    import pwm_spd_decode_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pwm_spd_decode.sv
// Recovers a signed speed from a complementary PWM pair by timing high time per period,
// flagging bad periods, complement violations and stalled inputs.
module pwm_spd_decode
    import pwm_spd_decode_pkg::*;
#(
    parameter int PERIOD   = PERIOD_DEF,
    parameter int DEAD_MAX = DEAD_MAX_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pwm_in,
    input  logic               pwm_in_n,
    output logic signed [10:0] spd,
    output logic               spd_vld,
    output logic               per_err,
    output logic               pair_err,
    output logic               stall
);

    logic pwm_s;
    logic pwmn_s;

    sync2 u_sync_p (.clk(clk), .rst_n(rst_n), .d_i(pwm_in),   .q_o(pwm_s));
    sync2 u_sync_n (.clk(clk), .rst_n(rst_n), .d_i(pwm_in_n), .q_o(pwmn_s));

    state_e      state_q, state_d;
    logic        now_q, prev_q, now_n_q;
    logic [11:0] per_cnt_q, per_cnt_d;
    logic [10:0] hi_cnt_q, hi_cnt_d;
    logic [7:0]  dead_cnt_q, dead_cnt_d;
    logic        pair_flag_q, pair_flag_d;
    logic [10:0] spd_q, spd_d;
    logic        vld_q, vld_d;
    logic        per_err_q, per_err_d;
    logic        pair_err_q, pair_err_d;

    logic        rise;
    logic        eq;
    logic        viol;
    logic        timeout;
    logic [12:0] per_inc;

    // The extra now/prev stage puts the strobes three clocks after raw pwm_in is first sampled high.
    assign rise    = now_q & ~prev_q;
    assign eq      = (now_q == now_n_q);
    assign viol    = eq && (int'(dead_cnt_q) == DEAD_MAX);
    assign per_inc = {1'b0, per_cnt_q} + 13'd1;
    assign timeout = (int'(per_inc) >= TIMEOUT);

    always_comb begin
        state_d     = state_q;
        spd_d       = spd_q;
        vld_d       = 1'b0;
        per_err_d   = 1'b0;
        pair_err_d  = viol;
        pair_flag_d = pair_flag_q | viol;
        per_cnt_d   = (per_cnt_q == 12'hFFF) ? per_cnt_q : per_cnt_q + 12'd1;
        hi_cnt_d    = (now_q && hi_cnt_q != 11'h7FF) ? hi_cnt_q + 11'd1 : hi_cnt_q;

        if (!eq) begin
            dead_cnt_d = 8'd0;
        end else if (int'(dead_cnt_q) <= DEAD_MAX) begin
            dead_cnt_d = dead_cnt_q + 8'd1;
        end else begin
            dead_cnt_d = dead_cnt_q;
        end

        if (rise) begin
            per_cnt_d   = 12'd1;
            hi_cnt_d    = 11'd1;
            pair_flag_d = viol;
            state_d     = MEASURE;
            case (state_q)
                MEASURE: begin
                    if (int'(per_cnt_q) == PERIOD) begin
                        if (!(pair_flag_q || viol)) begin
                            spd_d = hi_to_spd(hi_cnt_q);
                            vld_d = 1'b1;
                        end
                    end else begin
                        per_err_d = 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (timeout && (state_q == IDLE || state_q == MEASURE)) begin
            if (now_q) begin
                state_d = STALL_HI;
            end else begin
                state_d = STALL_LO;
                spd_d   = SPD_MIN;
                vld_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            now_q       <= 1'b0;
            prev_q      <= 1'b0;
            now_n_q     <= 1'b0;
            per_cnt_q   <= 12'd0;
            hi_cnt_q    <= 11'd0;
            dead_cnt_q  <= 8'd0;
            pair_flag_q <= 1'b0;
            spd_q       <= 11'd0;
            vld_q       <= 1'b0;
            per_err_q   <= 1'b0;
            pair_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            now_q       <= pwm_s;
            prev_q      <= now_q;
            now_n_q     <= pwmn_s;
            per_cnt_q   <= per_cnt_d;
            hi_cnt_q    <= hi_cnt_d;
            dead_cnt_q  <= dead_cnt_d;
            pair_flag_q <= pair_flag_d;
            spd_q       <= spd_d;
            vld_q       <= vld_d;
            per_err_q   <= per_err_d;
            pair_err_q  <= pair_err_d;
        end
    end

    assign spd      = spd_q;
    assign spd_vld  = vld_q;
    assign per_err  = per_err_q;
    assign pair_err = pair_err_q;
    assign stall    = (state_q == STALL_LO) || (state_q == STALL_HI);

endmodule

// File: tb/tb_pwm_spd_decode.sv
// Directed bench for pwm_spd_decode: drives whole PWM periods and checks strobes three clocks after each raw edge.
module tb_pwm_spd_decode;

    logic               clk      = 1'b0;
    logic               rst_n    = 1'b0;
    logic               pwm_in   = 1'b0;
    logic               pwm_in_n = 1'b1;
    logic signed [10:0] spd;
    logic [10:0]        spdU;
    logic               spd_vld;
    logic               per_err;
    logic               pair_err;
    logic               stall;

    int checks     = 0;
    int errors     = 0;
    int vldCnt     = 0;
    int perErrCnt  = 0;
    int pairErrCnt = 0;

    always #5 clk = ~clk;

    assign spdU = spd;

    pwm_spd_decode dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pwm_in   (pwm_in),
        .pwm_in_n (pwm_in_n),
        .spd      (spd),
        .spd_vld  (spd_vld),
        .per_err  (per_err),
        .pair_err (pair_err),
        .stall    (stall)
    );

    always @(negedge clk) begin
        if (spd_vld === 1'b1)  vldCnt++;
        if (per_err === 1'b1)  perErrCnt++;
        if (pair_err === 1'b1) pairErrCnt++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One PWM period starting with its raw rising edge; the edge that opens it judges the previous period.
    task automatic applyStimulus(input string tag, input int per, input int duty,
                                 input int ovStart, input int ovLen,
                                 input logic expVld, input logic expPerErr,
                                 input logic [10:0] expSpd, input logic expStallEarly,
                                 input int rstAt);
        for (int i = 0; i < per; i++) begin
            pwm_in   = (i < duty);
            pwm_in_n = (i >= ovStart && i < ovStart + ovLen) ? pwm_in : ~pwm_in;
            rst_n    = (i != rstAt);
            @(posedge clk);
            #1;
            if (i == 2) begin
                checkOutput({tag, "_early"}, {29'd0, spd_vld, per_err, stall}, {29'd0, 2'b00, expStallEarly});
            end
            if (i == 3) begin
                checkOutput({tag, "_vld"},   {31'd0, spd_vld}, {31'd0, expVld});
                checkOutput({tag, "_perr"},  {31'd0, per_err}, {31'd0, expPerErr});
                checkOutput({tag, "_spd"},   {21'd0, spdU},    {21'd0, expSpd});
                checkOutput({tag, "_stall"}, {31'd0, stall},   32'd0);
            end
            if (i == rstAt) begin
                checkOutput({tag, "_rst"}, {17'd0, spdU, spd_vld, per_err, pair_err, stall}, 32'd0);
            end
        end
    endtask

    initial begin
        int vBase;
        int k;

        rst_n    = 1'b0;
        pwm_in   = 1'b0;
        pwm_in_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_spd",   {21'd0, spdU},     32'd0);
        checkOutput("reset_vld",   {31'd0, spd_vld},  32'd0);
        checkOutput("reset_perr",  {31'd0, per_err},  32'd0);
        checkOutput("reset_pair",  {31'd0, pair_err}, 32'd0);
        checkOutput("reset_stall", {31'd0, stall},    32'd0);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        applyStimulus("idle_edge", 2048, 'h400,  -1,  0, 1'b0, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("mid_1",     2048, 'h400,  -1,  0, 1'b1, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("mid_2",     2048, 'h400,  -1,  0, 1'b1, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("to_600",    2048, 'h600,  -1,  0, 1'b1, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("d600_a",    2048, 'h600,  -1,  0, 1'b1, 1'b0, 11'h200, 1'b0, -1);
        applyStimulus("to_100",    2048, 'h100,  -1,  0, 1'b1, 1'b0, 11'h200, 1'b0, -1);
        applyStimulus("d100_a",    2048, 'h100,  -1,  0, 1'b1, 1'b0, 11'h500, 1'b0, -1);
        applyStimulus("ov10",      2048, 'h400, 100, 10, 1'b1, 1'b0, 11'h500, 1'b0, -1);
        applyStimulus("ov3",       2048, 'h400, 100,  3, 1'b0, 1'b0, 11'h500, 1'b0, -1);
        applyStimulus("to_2000",   2000, 1000,   -1,  0, 1'b1, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("p2000_a",   2000, 1000,   -1,  0, 1'b0, 1'b1, 11'h000, 1'b0, -1);
        applyStimulus("p2000_b",   2000, 1000,   -1,  0, 1'b0, 1'b1, 11'h000, 1'b0, -1);
        applyStimulus("back_2048", 2048, 'h400,  -1,  0, 1'b0, 1'b1, 11'h000, 1'b0, -1);
        applyStimulus("ok_2048",   2048, 'h400,  -1,  0, 1'b1, 1'b0, 11'h000, 1'b0, -1);

        checkOutput("vld_count",  vldCnt,     32'd9);
        checkOutput("perr_count", perErrCnt,  32'd3);
        checkOutput("pair_count", pairErrCnt, 32'd1);

        pwm_in   = 1'b0;
        pwm_in_n = 1'b1;
        repeat (1952) @(posedge clk);
        #1;
        checkOutput("stall_early", {31'd0, stall}, 32'd0);
        vBase = vldCnt;
        k = 0;
        while (stall !== 1'b1 && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput("stall_set", {31'd0, stall},   32'd1);
        checkOutput("stall_spd", {21'd0, spdU},    {21'd0, 11'h400});
        checkOutput("stall_vld", {31'd0, spd_vld}, 32'd1);
        repeat (100) @(posedge clk);
        #1;
        checkOutput("stall_single_vld", vldCnt - vBase, 32'd1);
        checkOutput("stall_hold", {31'd0, stall}, 32'd1);

        applyStimulus("stall_exit",    2048, 'h400, -1, 0, 1'b0, 1'b0, 11'h400, 1'b1, -1);
        applyStimulus("after_stall",   2048, 'h600, -1, 0, 1'b1, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("pre_rst",       2048, 'h600, -1, 0, 1'b1, 1'b0, 11'h200, 1'b0, 1800);
        applyStimulus("post_rst_idle", 2048, 'h600, -1, 0, 1'b0, 1'b0, 11'h000, 1'b0, -1);
        applyStimulus("post_rst_meas", 2048, 'h400, -1, 0, 1'b1, 1'b0, 11'h200, 1'b0, -1);

        checkOutput("pair_total", pairErrCnt, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
